// File: rtl/fillrect_pkg.sv
// Shared types and default geometry for the rectangle fill engine.
package fillrect_pkg;

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;
   typedef enum logic [1:0] {SOLID, XSTRIPE, YSTRIPE, CHECKER} mode_t;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int X_W_DEF      = 8;
   localparam int Y_W_DEF      = 7;
   localparam int COLOUR_W_DEF = 3;

endpackage

// File: rtl/fillrect_raster_counter.sv
// Row-major x/y scan counter over an inclusive rectangle; holds at the last pixel.
module raster_counter #(
   parameter int X_W = 8,
   parameter int Y_W = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           load,
   input  logic [X_W-1:0] xmin,
   input  logic [X_W-1:0] xmax,
   input  logic [Y_W-1:0] ymin,
   input  logic [Y_W-1:0] ymax,
   input  logic           step,
   output logic [X_W-1:0] x,
   output logic [Y_W-1:0] y,
   output logic           last
);

   logic [X_W-1:0] x_q, x_d, xmin_q, xmin_d, xmax_q, xmax_d;
   logic [Y_W-1:0] y_q, y_d, ymax_q, ymax_d;

   assign last = (x_q == xmax_q) && (y_q == ymax_q);
   assign x    = x_q;
   assign y    = y_q;

   always_comb begin
      x_d    = x_q;
      y_d    = y_q;
      xmin_d = xmin_q;
      xmax_d = xmax_q;
      ymax_d = ymax_q;
      if (load) begin
         x_d    = xmin;
         y_d    = ymin;
         xmin_d = xmin;
         xmax_d = xmax;
         ymax_d = ymax;
      end else if (step && !last) begin
         if (x_q == xmax_q) begin
            x_d = xmin_q;
            y_d = y_q + Y_W'(1);
         end else begin
            x_d = x_q + X_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q    <= '0;
         y_q    <= '0;
         xmin_q <= '0;
         xmax_q <= '0;
         ymax_q <= '0;
      end else begin
         x_q    <= x_d;
         y_q    <= y_d;
         xmin_q <= xmin_d;
         xmax_q <= xmax_d;
         ymax_q <= ymax_d;
      end
   end

endmodule

// File: rtl/fillrect.sv
// Rectangle fill engine: normalises and clips the corners, then plots one pixel per clock.
//
//   state | meaning
//   IDLE  | waiting for start; latches, sorts and clips operands
//   DRAW  | scanning the rectangle, one plot per cycle
//   DONE  | done asserted until start is released
module fillrect import fillrect_pkg::*; #(
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter int X_W      = X_W_DEF,
   parameter int Y_W      = Y_W_DEF,
   parameter int COLOUR_W = COLOUR_W_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [X_W-1:0]      x0,
   input  logic [X_W-1:0]      x1,
   input  logic [Y_W-1:0]      y0,
   input  logic [Y_W-1:0]      y1,
   input  logic [COLOUR_W-1:0] colour,
   input  logic [1:0]          mode,
   output logic                done,
   output logic [X_W-1:0]      vga_x,
   output logic [Y_W-1:0]      vga_y,
   output logic [COLOUR_W-1:0] vga_colour,
   output logic                vga_plot
);

   // One extra bit so a screen size equal to 2^W still compares correctly.
   localparam logic [X_W:0] XLIM  = (X_W+1)'(SCREEN_W);
   localparam logic [X_W:0] XLAST = (X_W+1)'(SCREEN_W - 1);
   localparam logic [Y_W:0] YLIM  = (Y_W+1)'(SCREEN_H);
   localparam logic [Y_W:0] YLAST = (Y_W+1)'(SCREEN_H - 1);

   state_t                state_q, state_d;
   mode_t                 mode_q, mode_d;
   logic [COLOUR_W-1:0]   colour_q, colour_d;
   logic                  done_q, done_d, plot_q, plot_d;
   logic [X_W-1:0]        vx_q, vx_d;
   logic [Y_W-1:0]        vy_q, vy_d;
   logic [COLOUR_W-1:0]   vc_q, vc_d;

   logic [X_W-1:0]        lo_x, hi_x, xmax_c;
   logic [Y_W-1:0]        lo_y, hi_y, ymax_c;
   logic                  empty;
   logic                  load, step, last;
   logic [X_W-1:0]        cnt_x;
   logic [Y_W-1:0]        cnt_y;
   logic [COLOUR_W-1:0]   pix_colour;

   always_comb begin
      lo_x   = (x0 < x1) ? x0 : x1;
      hi_x   = (x0 < x1) ? x1 : x0;
      lo_y   = (y0 < y1) ? y0 : y1;
      hi_y   = (y0 < y1) ? y1 : y0;
      xmax_c = ({1'b0, hi_x} > XLAST) ? XLAST[X_W-1:0] : hi_x;
      ymax_c = ({1'b0, hi_y} > YLAST) ? YLAST[Y_W-1:0] : hi_y;
      empty  = ({1'b0, lo_x} >= XLIM) || ({1'b0, lo_y} >= YLIM);
   end

   raster_counter #(.X_W(X_W), .Y_W(Y_W)) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .xmin (lo_x),
      .xmax (xmax_c),
      .ymin (lo_y),
      .ymax (ymax_c),
      .step (step),
      .x    (cnt_x),
      .y    (cnt_y),
      .last (last)
   );

   always_comb begin
      pix_colour = colour_q;
      case (mode_q)
         SOLID:   pix_colour = colour_q;
         XSTRIPE: pix_colour = cnt_x[COLOUR_W-1:0];
         YSTRIPE: pix_colour = cnt_y[COLOUR_W-1:0];
         CHECKER: pix_colour = (cnt_x[0] ^ cnt_y[0]) ? '0 : colour_q;
         default: pix_colour = colour_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      colour_d = colour_q;
      load     = 1'b0;
      step     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load     = 1'b1;
               mode_d   = mode_t'(mode);
               colour_d = colour;
               state_d  = empty ? DONE : DRAW;
            end
         end
         DRAW: begin
            step = 1'b1;
            if (last) state_d = DONE;
         end
         DONE: begin
            if (!start) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output stage trails the counter by one cycle, so DONE is seen one edge after the last plot.
   always_comb begin
      plot_d = (state_q == DRAW);
      done_d = (state_q == DONE);
      vx_d   = vx_q;
      vy_d   = vy_q;
      vc_d   = vc_q;
      if (state_q == DRAW) begin
         vx_d = cnt_x;
         vy_d = cnt_y;
         vc_d = pix_colour;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         mode_q   <= SOLID;
         colour_q <= '0;
         done_q   <= 1'b0;
         plot_q   <= 1'b0;
         vx_q     <= '0;
         vy_q     <= '0;
         vc_q     <= '0;
      end else begin
         state_q  <= state_d;
         mode_q   <= mode_d;
         colour_q <= colour_d;
         done_q   <= done_d;
         plot_q   <= plot_d;
         vx_q     <= vx_d;
         vy_q     <= vy_d;
         vc_q     <= vc_d;
      end
   end

   assign done       = done_q;
   assign vga_plot   = plot_q;
   assign vga_x      = vx_q;
   assign vga_y      = vy_q;
   assign vga_colour = vc_q;

endmodule

// File: tb/tb_fillrect.sv
// Scoreboard bench for fillrect: expected pixels are queued by stimulus, popped by a plot monitor.
module tb_fillrect;

   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] c;
   } pix_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] x0, x1;
   logic [6:0] y0, y1;
   logic [2:0] colour;
   logic [1:0] mode;
   logic       done;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] vga_colour;
   logic       vga_plot;

   pix_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   plot_cnt = 0;

   fillrect dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x0         (x0),
      .x1         (x1),
      .y0         (y0),
      .y1         (y1),
      .colour     (colour),
      .mode       (mode),
      .done       (done),
      .vga_x      (vga_x),
      .vga_y      (vga_y),
      .vga_colour (vga_colour),
      .vga_plot   (vga_plot)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, got, got, want, want);
      end
   endtask

   // Monitor: every plot must match the head of the expected queue.
   always @(negedge clk) begin
      if (vga_plot) begin
         pix_t got;
         plot_cnt++;
         got = '{x: vga_x, y: vga_y, c: vga_colour};
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d want no plot", vga_x, vga_y, vga_colour);
         end else begin
            pix_t want;
            want = exp_q.pop_front();
            check($sformatf("pixel(%0d,%0d)", want.x, want.y), int'(got), int'(want));
         end
      end
   end

   task automatic push(input int px, input int py, input int pc);
      pix_t p;
      p.x = 8'(px);
      p.y = 7'(py);
      p.c = 3'(pc);
      exp_q.push_back(p);
   endtask

   task automatic set_ops(input int a0, input int a1, input int b0, input int b1,
                          input int c, input int m);
      x0     = 8'(a0);
      x1     = 8'(a1);
      y0     = 7'(b0);
      y1     = 7'(b1);
      colour = 3'(c);
      mode   = 2'(m);
   endtask

   // Called just after the edge that sampled start (edge 0).
   task automatic wait_fill(input string name, input int exp_n);
      int base;
      int done_edge;
      int gap;
      base      = plot_cnt;
      done_edge = -1;
      gap       = 0;
      for (int i = 1; i <= exp_n + 20; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            done_edge = i;
            break;
         end
         if (i <= exp_n && !vga_plot) gap = 1;
      end
      @(negedge clk);
      check({name, " done_edge"}, done_edge, exp_n + 1);
      check({name, " plot_gap"}, gap, 0);
      check({name, " plot_count"}, plot_cnt - base, exp_n);
      check({name, " leftover_expected"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic release_start(input string name, input bit restart);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check({name, " done_held"}, int'(done), 1);
      if (restart) start = 1'b1;
      @(posedge clk);
      #1;
      check({name, " done_dropped"}, int'(done), 0);
   endtask

   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      set_ops(0, 0, 0, 0, 0, 0);
      repeat (3) @(posedge clk);
      #1;
      check("reset done", int'(done), 0);
      check("reset plot", int'(vga_plot), 0);
      check("reset x", int'(vga_x), 0);
      check("reset y", int'(vga_y), 0);
      check("reset colour", int'(vga_colour), 0);
      @(negedge clk);
      rst = 1'b0;

      // Full screen, SOLID colour 5
      for (int yy = 0; yy < 120; yy++)
         for (int xx = 0; xx < 160; xx++)
            push(xx, yy, 5);
      set_ops(0, 159, 0, 119, 5, 0);
      launch();
      wait_fill("full", 19200);
      release_start("full", 1'b0);

      // Swapped corners, XSTRIPE
      push(10, 5, 2); push(11, 5, 3); push(12, 5, 4);
      push(10, 6, 2); push(11, 6, 3); push(12, 6, 4);
      set_ops(12, 10, 6, 5, 1, 1);
      launch();
      wait_fill("swapped", 6);
      release_start("swapped", 1'b0);

      // Clipped at the right edge
      for (int xx = 150; xx < 160; xx++) push(xx, 119, 2);
      set_ops(150, 255, 119, 119, 2, 0);
      launch();
      wait_fill("clip", 10);
      release_start("clip", 1'b0);

      // Empty rectangle, then immediate restart into a CHECKER fill
      set_ops(170, 170, 0, 0, 3, 0);
      launch();
      wait_fill("empty", 0);
      push(0, 0, 7); push(1, 0, 0); push(0, 1, 0); push(1, 1, 7);
      set_ops(0, 1, 0, 1, 7, 3);
      release_start("empty", 1'b1);
      set_ops(40, 90, 20, 30, 2, 0);
      wait_fill("checker", 4);
      release_start("checker", 1'b0);

      // Reset pulsed after five plots of a full-screen fill
      for (int xx = 0; xx < 5; xx++) push(xx, 0, 1);
      set_ops(0, 159, 0, 119, 1, 0);
      launch();
      repeat (5) @(posedge clk);
      @(negedge clk);
      #1;
      rst   = 1'b1;
      start = 1'b0;
      #1;
      check("async_rst plot", int'(vga_plot), 0);
      check("async_rst x", int'(vga_x), 0);
      check("async_rst y", int'(vga_y), 0);
      check("async_rst colour", int'(vga_colour), 0);
      check("async_rst done", int'(done), 0);
      check("rst plots_seen", plot_cnt, 19200 + 6 + 10 + 4 + 5);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("post_rst leftover", exp_q.size(), 0);
      check("post_rst done", int'(done), 0);
      exp_q.delete();

      push(5, 3, 6); push(6, 3, 6); push(5, 4, 6); push(6, 4, 6);
      set_ops(6, 5, 4, 3, 6, 0);
      launch();
      wait_fill("after_rst", 4);
      release_start("after_rst", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fillrect.md
# fillrect

Parametrised successor to the full-screen fill engine. It rasterises an axis-aligned rectangle, from full screen down to a single pixel, into the VGA adapter's pixel-write port at one pixel per clock. It supports four colour modes, clips to the screen, and normalises swapped corners. It sits between the top-level task controller (start/done handshake) and the VGA adapter (vga_x/vga_y/vga_colour/vga_plot).

## Interface
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows
- X_W, 8, x coordinate width; must satisfy 2^X_W >= SCREEN_W
- Y_W, 7, y coordinate width; must satisfy 2^Y_W >= SCREEN_H
- COLOUR_W, 3, colour width
- clk  input  1  system clock; all state changes on the rising edge
- rst  input  1  reset; asynchronous, active-high
- start  input  1  request; held high until done is seen
- x0, x1  input  X_W  corner columns; any order
- y0, y1  input  Y_W  corner rows; any order
- colour  input  COLOUR_W  base colour
- mode  input  2  0 SOLID, 1 XSTRIPE, 2 YSTRIPE, 3 CHECKER
- done  output  1  fill complete
- vga_x  output  X_W  pixel column
- vga_y  output  Y_W  pixel row
- vga_colour  output  COLOUR_W  pixel colour
- vga_plot  output  1  pixel write strobe

## Operation
- States: IDLE, DRAW, DONE.
- **IDLE**
  - On start=1: latch the operands.
    - xmin=min(x0,x1), xmax=min(max(x0,x1), SCREEN_W-1).
    - ymin and ymax computed the same way against SCREEN_H-1.
    - mode and colour are also latched.
  - If xmin>=SCREEN_W or ymin>=SCREEN_H, the rectangle is empty: go to DONE with no plots.
  - Otherwise go to DRAW with the scan position at (xmin, ymin).
- **DRAW**
  - Each cycle: vga_plot=1 at the current (x, y).
  - Scan order is row-major: x increments first. At xmax, x reloads xmin and y increments.
  - The transition after plotting (xmax, ymax) is to DONE.
- Colour, evaluated per pixel from the latched values:
  - SOLID: colour.
  - XSTRIPE: x[COLOUR_W-1:0].
  - YSTRIPE: y[COLOUR_W-1:0].
  - CHECKER: colour if x[0]^y[0]=0, else 0.
- **DONE**
  - done=1 and vga_plot=0.
  - Held while start=1.
  - On start=0, go to IDLE.
- Inputs changing during DRAW have no effect; only the latched copies are used.
- Counter arithmetic is unsigned at X_W/Y_W width. The counters never exceed xmax/ymax, so there is no wrap.

## Timing
- All outputs are registered.
- Reset values:
  - State IDLE.
  - done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Rectangle of W×H pixels, with start sampled high at edge 0:
  - vga_plot=1 for edges 1..W·H.
  - done=1 from edge W·H+1.
- Empty rectangle: done=1 at edge 1; vga_plot is never asserted.
- Releasing start: start low sampled at edge k in DONE gives done=0 at edge k+1. A new start is accepted at edge k+1 at the earliest.
- Start dropped during DRAW: ignored; the fill completes.
- rst during DRAW: immediate return to reset values; no further plots.
- Throughput is one pixel per clock with no stalls. A full 160×120 fill takes 19200 plot cycles.

## Structure
- Package fillrect_pkg:
  - state_t enum {IDLE, DRAW, DONE}.
  - mode_t enum {SOLID, XSTRIPE, YSTRIPE, CHECKER}.
  - Default screen and width constants.
- Sub-module raster_counter (X_W, Y_W):
  - Nested x/y counter.
  - Inputs: load with bounds (xmin, xmax, ymin, ymax), and step.
  - Outputs: x, y, last (high at (xmax, ymax)).
- Top level: FSM, operand latch/clip/normalise logic, colour mux, output registers.

## Test plan
- Full screen, SOLID, colour=3'b101:
  - Exactly 19200 plots, all with colour 5.
  - First plot at (0,0), last at (159,119).
  - done at edge 19201.
- x0=12, y0=6, x1=10, y1=5 (swapped corners), XSTRIPE:
  - 6 plots, in order (10,5) (11,5) (12,5) (10,6) (11,6) (12,6).
  - Colours 2, 3, 4, 2, 3, 4.
  - done at edge 7.
- x0=150, x1=255, y0=y1=119, SOLID:
  - Clipped to 10 plots, x=150..159 at y=119.
  - No x>159 is ever plotted.
- x0=x1=170 (empty rectangle):
  - done=1 at edge 1, zero plots.
  - Drop start: done=0 on the next edge, and a new start is accepted.
- CHECKER, colour=7, rectangle (0,0)-(1,1):
  - Colours 7, 0, 0, 7.
  - Inputs changed mid-fill do not alter any pixel.
- rst pulsed after 5 plots of a full-screen fill:
  - Outputs return to 0 asynchronously; no plots afterwards.
  - After rst is released, a new fill restarts at (xmin, ymin).
